// File: rtl/sram_bank_rf_if.sv
// ---------------------------------------------------------------------------
// sram_bank_rf_if
//    Request/response bundle between a bus front end (master) and one
//    sram_bank_rf storage bank (slave).
//
//    Request channel : req_valid/req_ready handshake carrying we, addr,
//                      wdata and byte-lane write strobes.
//    Response channel: rsp_valid/rsp_ready handshake carrying read data.
//    Clear control   : init_start pulse requests a full clear; init_busy
//                      reports that the clear sequencer is running.
// ---------------------------------------------------------------------------
interface sram_bank_rf_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int WORD_SIZE  = 32
);
   localparam int NUM_LANES = WORD_SIZE / 8;

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [WORD_SIZE-1:0]  req_wdata;
   logic [NUM_LANES-1:0]  req_wstrb;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [WORD_SIZE-1:0]  rsp_rdata;

   logic                  init_start;
   logic                  init_busy;

   // Front end / arbiter side.
   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wstrb,
      input  req_ready,
      input  rsp_valid, rsp_rdata,
      output rsp_ready,
      output init_start,
      input  init_busy
   );

   // Storage bank side.
   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
      output req_ready,
      output rsp_valid, rsp_rdata,
      input  rsp_ready,
      input  init_start,
      output init_busy
   );
endinterface : sram_bank_rf_if

// File: rtl/sram_bank_rf.sv
// ---------------------------------------------------------------------------
// sram_bank_rf
//    Register-based single-port SRAM bank with byte-lane write strobes, a
//    one-entry read response buffer with backpressure, and a clear sequencer
//    that writes INIT_VALUE to every word after reset or on init_start.
//
//    Ports:
//       clk  : clock, all state updates on the rising edge
//       rst  : synchronous active-high reset (restarts the clear sequence)
//       bus  : sram_bank_rf_if.slave (request, response and clear control)
//
//    Behaviour summary:
//       INIT : one word cleared per cycle, counter 0..DEPTH-1, no requests.
//       IDLE : req_ready = !rsp_valid || rsp_ready; writes merge per lane,
//              reads return data one cycle after acceptance.
// ---------------------------------------------------------------------------
module sram_bank_rf #(
   parameter int                  ADDR_WIDTH = 8,
   parameter int                  WORD_SIZE  = 32,
   parameter logic [WORD_SIZE-1:0] INIT_VALUE = '0
) (
   input logic           clk,
   input logic           rst,
   sram_bank_rf_if.slave bus
);

   localparam int DEPTH     = 1 << ADDR_WIDTH;
   localparam int NUM_LANES = WORD_SIZE / 8;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q,   cnt_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [WORD_SIZE-1:0]  rsp_rdata_q, rsp_rdata_d;

   // NOTE: the storage array has no reset; its defined contents come from
   // the clear sequencer, which keeps the array a plain register file.
   logic [WORD_SIZE-1:0]  mem_q [DEPTH];

   logic req_ready;
   logic req_fire;
   logic wr_fire;
   logic rd_fire;
   logic cnt_last;

   // Ready depends only on state and the response buffer, never on
   // req_valid, so the upstream arbiter sees no combinational loop.
   assign req_ready = (state_q == ST_IDLE) && (!rsp_valid_q || bus.rsp_ready);
   assign req_fire  = bus.req_valid && req_ready;
   assign wr_fire   = req_fire &&  bus.req_we;
   assign rd_fire   = req_fire && !bus.req_we;

   // The counter's terminal value is all ones; no separate wrap logic needed.
   assign cnt_last  = &cnt_q;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default first so that no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;

      unique case (state_q)
         ST_INIT: begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (cnt_last) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         ST_IDLE: begin
            // A request accepted this cycle still completes; the clear
            // starts on the following cycle.
            if (bus.init_start) begin
               state_d = ST_INIT;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_INIT;
            cnt_d   = '0;
         end
      endcase

      // One-entry response buffer. A pending response survives INIT and is
      // released only by the consumer; a new read overwrites it only when
      // the old one is being taken this same cycle (guaranteed by req_ready).
      if (rd_fire) begin
         rsp_valid_d = 1'b1;
         rsp_rdata_d = mem_q[bus.req_addr];
      end else if (bus.rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Control and response registers
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_INIT;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // ------------------------------------------------------------------------
   // Storage array
   // ------------------------------------------------------------------------
   // During rst nothing is written; words already cleared before a reset
   // are simply cleared again by the restarted sequence.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == ST_INIT) begin
            mem_q[cnt_q] <= INIT_VALUE;
         end else if (wr_fire) begin
            // Unstrobed lanes keep their old contents; wstrb=0 is a no-op.
            for (int i = 0; i < NUM_LANES; i++) begin
               if (bus.req_wstrb[i]) begin
                  mem_q[bus.req_addr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.init_busy = (state_q == ST_INIT);

endmodule : sram_bank_rf

// File: tb/tb_sram_bank_rf.sv
// ---------------------------------------------------------------------------
// tb_sram_bank_rf
//    Self-checking bench for sram_bank_rf with a 16-word bank and
//    INIT_VALUE = 32'hDEADBEEF. A word-level model tracks memory contents;
//    expected read data is queued when a read is driven and compared when
//    the bank presents its response.
// ---------------------------------------------------------------------------
module tb_sram_bank_rf;

   localparam int          AW    = 4;
   localparam int          WS    = 32;
   localparam int          DEPTH = 1 << AW;
   localparam logic [31:0] INITV = 32'hDEADBEEF;

   logic clk = 1'b0;
   logic rst = 1'b1;

   sram_bank_rf_if #(.ADDR_WIDTH(AW), .WORD_SIZE(WS)) bus ();

   sram_bank_rf #(
      .ADDR_WIDTH (AW),
      .WORD_SIZE  (WS),
      .INIT_VALUE (INITV)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] mdl [DEPTH];
   logic [31:0] exp_q [$];

   // Inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) mdl[i] = INITV;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
      for (int i = 0; i < 4; i++) if (s[i]) mdl[a][8*i +: 8] = d[8*i +: 8];
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = a;
      bus.req_wdata = d;
      bus.req_wstrb = s;
      tick();
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a);
      exp_q.push_back(mdl[a]);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = a;
      tick();
      bus.req_valid = 1'b0;
   endtask

   // Waits (bounded) for a response, consumes it, returns it with the
   // expected value from the head of the scoreboard.
   task automatic pop_rsp(output logic got, output logic [31:0] act, output logic [31:0] exp);
      int n = 0;
      bus.rsp_ready = 1'b1;
      while (!bus.rsp_valid && n < 8) begin
         tick();
         n++;
      end
      got = bus.rsp_valid;
      act = bus.rsp_rdata;
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
      if (got) tick();
   endtask

   // Number of sampled cycles with init_busy=1, bounded.
   task automatic count_busy(output int n);
      n = 0;
      while (bus.init_busy && n < 40) begin
         n++;
         tick();
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      int          n;
      logic        got;
      logic [31:0] act, exp;
      rst = 1'b1;
      tick();
      checks++;
      if (bus.init_busy !== 1'b1 || bus.req_ready !== 1'b0 ||
          bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_state: busy=%b ready=%b rsp_valid=%b rdata=%h, want 1 0 0 00000000",
                  bus.init_busy, bus.req_ready, bus.rsp_valid, bus.rsp_rdata);
      end
      tick();
      rst = 1'b0;
      count_busy(n);
      checks++;
      if (n !== DEPTH || bus.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_clear_len: busy cycles=%0d ready=%b, want %0d 1", n, bus.req_ready, DEPTH);
      end
      model_clear();
      for (int a = 0; a < DEPTH; a++) begin
         rd(AW'(a));
         pop_rsp(got, act, exp);
         checks++;
         if (!got || act !== exp) begin
            failures++;
            $display("FAIL reset_read[%0d]: got=%b data=%h, want %h", a, got, act, exp);
         end
      end
   endtask

   task automatic test_byte_strobe();
      logic        got;
      logic [31:0] act, exp;
      wr(4'd3, 32'h11223344, 4'hF);
      wr(4'd3, 32'hAABBCCDD, 4'b0101);
      rd(4'd3);
      pop_rsp(got, act, exp);
      checks++;
      if (!got || act !== 32'h11BB33DD || exp !== 32'h11BB33DD) begin
         failures++;
         $display("FAIL strobe_merge: got=%b data=%h, want 11bb33dd", got, act);
      end
      wr(4'd3, 32'hFFFFFFFF, 4'h0);
      rd(4'd3);
      pop_rsp(got, act, exp);
      checks++;
      if (!got || act !== exp) begin
         failures++;
         $display("FAIL strobe_zero: got=%b data=%h, want %h", got, act, exp);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] e1;
      wr(4'd1, 32'hA1A1A1A1, 4'hF);
      wr(4'd2, 32'hB2B2B2B2, 4'hF);
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = 4'd1;
      exp_q.push_back(mdl[1]);
      #1;
      checks++;
      if (bus.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_first_ready: ready=%b, want 1", bus.req_ready);
      end
      tick();
      bus.req_addr = 4'd2;
      exp_q.push_back(mdl[2]);
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++;
         if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp_q[0]) begin
            failures++;
            $display("FAIL bp_stall[%0d]: ready=%b valid=%b data=%h, want 0 1 %h",
                     c, bus.req_ready, bus.rsp_valid, bus.rsp_rdata, exp_q[0]);
         end
         tick();
      end
      bus.rsp_ready = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_release_ready: ready=%b, want 1", bus.req_ready);
      end
      tick();
      bus.req_valid = 1'b0;
      e1 = exp_q.pop_front();
      e1 = exp_q.pop_front();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e1) begin
         failures++;
         $display("FAIL bp_second: valid=%b data=%h, want 1 %h", bus.rsp_valid, bus.rsp_rdata, e1);
      end
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_drain: valid=%b, want 0", bus.rsp_valid);
      end
   endtask

   task automatic test_read_after_write();
      logic [31:0] e;
      bus.rsp_ready = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 4'd7;
      bus.req_wdata = 32'h0000CAFE;
      bus.req_wstrb = 4'hF;
      mdl[7] = 32'h0000CAFE;
      tick();
      bus.req_we = 1'b0;
      exp_q.push_back(mdl[7]);
      tick();
      bus.req_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e) begin
         failures++;
         $display("FAIL raw: valid=%b data=%h, want 1 %h", bus.rsp_valid, bus.rsp_rdata, e);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] e;
      for (int a = 8; a < 12; a++) wr(AW'(a), 32'h0B0B0000 + a, 4'hF);
      bus.rsp_ready = 1'b1;
      bus.req_we    = 1'b0;
      for (int a = 8; a < 12; a++) begin
         bus.req_valid = 1'b1;
         bus.req_addr  = AW'(a);
         exp_q.push_back(mdl[a]);
         tick();
         e = exp_q.pop_front();
         checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e) begin
            failures++;
            $display("FAIL b2b[%0d]: valid=%b data=%h, want 1 %h", a, bus.rsp_valid, bus.rsp_rdata, e);
         end
      end
      bus.req_valid = 1'b0;
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_drain: valid=%b, want 0", bus.rsp_valid);
      end
   endtask

   task automatic test_init_start();
      int          n;
      logic        got;
      logic [31:0] act, exp;
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_addr   = 4'd0;
      bus.req_wdata  = 32'h5;
      bus.req_wstrb  = 4'hF;
      bus.init_start = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL init_start_accept: ready=%b, want 1", bus.req_ready);
      end
      tick();
      bus.req_valid  = 1'b0;
      bus.init_start = 1'b0;
      // Hold a request and re-pulse init_start mid-clear; both must be ignored.
      n = 0;
      bus.req_valid = 1'b1;
      while (bus.init_busy && n < 40) begin
         bus.init_start = (n == 5);
         #1;
         if (bus.req_ready !== 1'b0) n = 100;
         else begin
            n++;
            tick();
         end
      end
      bus.req_valid  = 1'b0;
      bus.init_start = 1'b0;
      checks++;
      if (n !== DEPTH) begin
         failures++;
         $display("FAIL init_start_len: busy-not-ready cycles=%0d, want %0d", n, DEPTH);
      end
      model_clear();
      rd(4'd0);
      pop_rsp(got, act, exp);
      checks++;
      if (!got || act !== exp) begin
         failures++;
         $display("FAIL init_start_read0: got=%b data=%h, want %h", got, act, exp);
      end
   endtask

   task automatic test_reset_mid_clear();
      int          n;
      logic        got;
      logic [31:0] act, exp;
      wr(4'd5, 32'h55AA55AA, 4'hF);
      bus.rsp_ready = 1'b0;
      rd(4'd5);
      bus.init_start = 1'b1;
      tick();
      bus.init_start = 1'b0;
      repeat (9) tick();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.init_busy !== 1'b1 || bus.rsp_rdata !== exp_q[0]) begin
         failures++;
         $display("FAIL pending_through_init: valid=%b busy=%b data=%h, want 1 1 %h",
                  bus.rsp_valid, bus.init_busy, bus.rsp_rdata, exp_q[0]);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      void'(exp_q.pop_front());
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.init_busy !== 1'b1) begin
         failures++;
         $display("FAIL mid_reset_state: valid=%b busy=%b, want 0 1", bus.rsp_valid, bus.init_busy);
      end
      count_busy(n);
      checks++;
      if (n !== DEPTH) begin
         failures++;
         $display("FAIL mid_reset_len: busy cycles=%0d, want %0d", n, DEPTH);
      end
      model_clear();
      bus.rsp_ready = 1'b1;
      rd(4'd5);
      pop_rsp(got, act, exp);
      checks++;
      if (!got || act !== exp) begin
         failures++;
         $display("FAIL mid_reset_read5: got=%b data=%h, want %h", got, act, exp);
      end
      checks++;
      if (exp_q.size() !== 0) begin
         failures++;
         $display("FAIL scoreboard_empty: left=%0d, want 0", exp_q.size());
      end
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.req_wstrb  = '0;
      bus.rsp_ready  = 1'b1;
      bus.init_start = 1'b0;
      #2;
      test_reset();
      test_byte_strobe();
      test_backpressure();
      test_read_after_write();
      test_back_to_back();
      test_init_start();
      test_reset_mid_clear();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_sram_bank_rf

// File: doc/sram_bank_rf.md
# sram_bank_rf

Parametrised, register-based single-port SRAM bank. It succeeds the fixed 32-bit, ungated register bank with a synchronous request/response handshake, byte-lane write strobes, output backpressure, and a hardware clear sequencer that initialises every word after reset or on command. It sits between a bus/arbiter front end and the storage array, one instance per bank.

## Interface

Parameters:
- ADDR_WIDTH, 8: address bits; depth DEPTH = 2^ADDR_WIDTH words.
- WORD_SIZE, 32: data bits per word; must be a multiple of 8.
- INIT_VALUE, 0: WORD_SIZE-bit value written to every word by the clear sequencer.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  bank can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  word address.
- req_wdata  input  WORD_SIZE  write data.
- req_wstrb  input  WORD_SIZE/8  byte-lane write enables; lane i covers bits [8i+7:8i].
- rsp_valid  output  1  read data available.
- rsp_ready  input  1  consumer takes read data.
- rsp_rdata  output  WORD_SIZE  read data; held stable while rsp_valid=1 and rsp_ready=0.
- init_start  input  1  request a full clear to INIT_VALUE.
- init_busy  output  1  clear sequencer active.

## Operation

- Two states: INIT and IDLE. Reset enters INIT with the clear counter at 0.
- INIT: one word per cycle, Mem[cnt] <= INIT_VALUE, cnt increments 0 to DEPTH-1. After the write to DEPTH-1, go to IDLE. No requests are accepted; req_ready=0.
- IDLE: req_ready = !rsp_valid || rsp_ready. A request is accepted when req_valid && req_ready.
- Accepted write: for each lane i with req_wstrb[i]=1, Mem[req_addr] lane i <= req_wdata lane i. Other lanes are unchanged. No response is generated. wstrb=0 is a legal no-op.
- Accepted read: rsp_rdata <= Mem[req_addr] and rsp_valid <= 1 on the next edge.
- Response buffer: one entry. rsp_valid clears on an edge where rsp_ready=1 and no new read is accepted. Back-to-back reads with rsp_ready held high give one response per cycle.
- Read after write to the same address in the next cycle returns the new data. There is a single port, so no same-cycle conflict exists.
- init_start in IDLE: a request accepted in the same cycle completes normally, and INIT begins next cycle. init_start is ignored while in INIT.
- A pending response stays valid through INIT until consumed.
- Address out of range is impossible by width. No wrap logic is required beyond the counter's terminal compare.

## Timing

- During rst: on the first edge with rst=1, state becomes INIT, cnt=0, init_busy=1, req_ready=0, rsp_valid=0, rsp_rdata=0.
- Clear duration: after rst deasserts, INIT lasts exactly DEPTH cycles. init_busy falls and req_ready rises on the edge after the last clear write.
- Clear via init_start: the same DEPTH cycles, starting the edge after init_start is sampled in IDLE.
- Read latency: 1 cycle from acceptance to rsp_valid.
- Write latency: 1 cycle; data is visible to a read accepted on the next cycle.
- rst asserted mid-INIT or mid-transfer: the sequencer restarts at cnt=0, and any pending response is dropped (rsp_valid=0). Memory contents other than words cleared so far are undefined until the clear completes.
- req_ready is combinational on rsp_valid, rsp_ready and state only. It does not depend on req_valid.

## Test plan

- Reset/clear (ADDR_WIDTH=4, INIT_VALUE=32'hDEADBEEF): pulse rst for 2 cycles. Required: init_busy=1 for exactly 16 cycles after release, then 0. Reads of addresses 0..15 each return 32'hDEADBEEF.
- Byte strobes: write 32'h11223344 to addr 3 with wstrb=4'hF, then 32'hAABBCCDD with wstrb=4'b0101. A read of addr 3 returns 32'h11BB33DD.
- Backpressure: issue reads of addr 1 and 2 back to back with rsp_ready=0. Required: the first is accepted, req_ready=0 next cycle, and rsp_rdata is stable at Mem[1]. Raise rsp_ready: the second is accepted in the same cycle and Mem[2] appears the following cycle.
- Read-after-write: write 32'h0000CAFE to addr 7 at cycle N, then read addr 7 at N+1. Required: rsp_valid at N+2 with 32'h0000CAFE.
- init_start with a concurrent write: write 32'h5 to addr 0 in the same cycle as init_start. Required: req_ready=0 for the next 16 cycles, and a read of addr 0 afterwards returns INIT_VALUE.
- Reset mid-clear: assert rst at clear cycle 9. Required: rsp_valid=0 and the clear restarts from 0, taking a full 16 cycles after release.
